// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding, FSM state type
// and a PC alignment helper.
package fetch_unit_pkg;

  // addi $0,$0,0 -- the bubble decode sees whenever fetch has nothing to hand over.
  localparam logic [31:0] NOP_WORD = 32'h2000_0000;

  // Fetch controller states.
  typedef enum logic [1:0] {
    StIdle,  // one settling cycle after reset
    StReq,   // request presented to instruction memory
    StWait,  // request accepted, waiting for read data
    StHold   // data returned during a decode stall, parked in the hold buffer
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, runs the req/ready + rvalid handshake to
// instruction memory and drives the write side of the F/D pipeline register. Delivery
// to decode is combinational from rvalid (or the hold buffer), so a fetch costs two
// cycles: one presenting the request, one receiving the data.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  // decode / later-stage control
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // F/D pipeline register
  output logic        fd_write_en,
  output logic        fd_flush,
  output logic [31:0] pc_value_next,
  output logic [31:0] next_instruction
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic [31:0]  hold_q, hold_d;
  // Address of the request being presented. Latched on entry to StReq so that a redirect
  // arriving before imem_ready cannot move an address memory has already seen.
  logic [31:0]  req_addr_q, req_addr_d;

  logic         rsp_fire;  // memory response consumed this cycle
  logic         rsp_good;  // response is right-path and not overridden by a redirect
  logic         deliver;   // an instruction is handed to decode this cycle
  logic [31:0]  pc_plus4;

  // Response qualification and delivery decision shared by next-state and output logic.
  always_comb begin
    rsp_fire = (state_q == StWait) && imem_rvalid;
    rsp_good = rsp_fire && !kill_q && !redirect_valid;
    deliver  = !stall && (rsp_good || ((state_q == StHold) && !redirect_valid));
    pc_plus4 = pc_q + 32'd4;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      hold_q     <= '0;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      hold_q     <= hold_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Next-state, PC, kill flag and hold buffer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    hold_d  = hold_q;

    if (deliver) begin
      pc_d = pc_plus4;
    end
    // A redirect wins over any sequential PC advance.
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        // The request cannot be withdrawn, so its eventual data is marked wrong-path.
        if (redirect_valid) begin
          kill_d = 1'b1;
        end
        if (imem_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (rsp_fire) begin
          kill_d = 1'b0;
          if (rsp_good && stall) begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end else begin
            // delivered, squashed by kill, or discarded by a same-cycle redirect
            state_d = StReq;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      StHold: begin
        // Either the buffer drains to decode or a redirect drops it.
        if (redirect_valid || !stall) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    req_addr_d = req_addr_q;
    if ((state_d == StReq) && (state_q != StReq)) begin
      req_addr_d = pc_d;
    end
  end

  // Memory request and F/D register controls.
  always_comb begin
    imem_req         = (state_q == StReq);
    imem_addr        = req_addr_q;
    fd_write_en      = 1'b0;
    fd_flush         = 1'b0;
    pc_value_next    = '0;
    next_instruction = NOP_INSTR;

    // Reset forces the F/D controls quiet even though the async reset already holds StIdle.
    if (!rst) begin
      if (redirect_valid) begin
        fd_write_en = 1'b1;
        fd_flush    = 1'b1;
      end else if (stall) begin
        fd_write_en = 1'b0;
        fd_flush    = 1'b0;
      end else if (deliver) begin
        fd_write_en      = 1'b1;
        pc_value_next    = pc_plus4;
        next_instruction = (state_q == StHold) ? hold_q : imem_rdata;
      end else begin
        // Bubble: never let decode re-latch a stale instruction.
        fd_write_en = 1'b1;
        fd_flush    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req, fd_write_en, fd_flush;
  logic [31:0] imem_addr, pc_value_next, next_instruction;
  logic        w_imem_req, w_fd_write_en, w_fd_flush;
  logic [31:0] w_imem_addr, w_pc_value_next, w_next_instruction;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the fetch stream: architectural PC, outstanding request, parked data.
  logic [31:0] m_pc;
  bit          m_idle;       // first cycle out of reset, no request yet
  bit          m_out;        // a request has been accepted and awaits data
  bit          m_wrong;      // the outstanding request is wrong-path
  bit          m_pend;       // returned data waiting out a stall
  logic [31:0] m_pend_data;
  bit          m_pres;       // a request was shown last cycle and not accepted
  bit          m_pres_wrong;
  logic [31:0] m_pres_addr;
  int          mem_cnt;      // cycles until memory answers the outstanding request

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .fd_write_en     (fd_write_en),
    .fd_flush        (fd_flush),
    .pc_value_next   (pc_value_next),
    .next_instruction(next_instruction)
  );

  // Second instance shares all stimulus; used only to observe PC wrap from the top word.
  fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INSTR(NOP)
  ) u_wrap (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (w_imem_req),
    .imem_addr       (w_imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .fd_write_en     (w_fd_write_en),
    .fd_flush        (w_fd_flush),
    .pc_value_next   (w_pc_value_next),
    .next_instruction(w_next_instruction)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_idle = 1; m_out = 0; m_wrong = 0; m_pend = 0;
    m_pres = 0; m_pres_wrong = 0; mem_cnt = 0;
  endtask

  task automatic idle_inputs();
    stall = 0; redirect_valid = 0; redirect_pc = '0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
  endtask

  // One clock with current inputs: check outputs against the model, then advance it.
  task automatic cyc();
    logic        resp, good, exp_req, dlv, exp_we, exp_fl;
    logic [31:0] exp_addr, exp_ni;
    #1;
    resp     = imem_rvalid && m_out;
    good     = resp && !m_wrong && !redirect_valid;
    exp_req  = !m_idle && !m_out && !m_pend;
    exp_addr = m_pres ? m_pres_addr : m_pc;
    dlv      = !redirect_valid && !stall && (m_pend || good);
    exp_ni   = m_pend ? m_pend_data : imem_rdata;
    if (redirect_valid)  {exp_we, exp_fl} = 2'b11;
    else if (stall)      {exp_we, exp_fl} = 2'b00;
    else if (dlv)        {exp_we, exp_fl} = 2'b10;
    else                 {exp_we, exp_fl} = 2'b11;

    n_checks++;
    if (imem_req !== exp_req) begin
      n_fail++; $display("FAIL model_req t=%0t got=%b want=%b", $time, imem_req, exp_req);
    end
    if (exp_req) begin
      n_checks++;
      if (imem_addr !== exp_addr) begin
        n_fail++; $display("FAIL model_addr t=%0t got=%h want=%h", $time, imem_addr, exp_addr);
      end
    end
    n_checks++;
    if ({fd_write_en, fd_flush} !== {exp_we, exp_fl}) begin
      n_fail++;
      $display("FAIL model_we_flush t=%0t got=%b%b want=%b%b", $time, fd_write_en, fd_flush,
               exp_we, exp_fl);
    end
    if (dlv) begin
      n_checks++;
      if (next_instruction !== exp_ni || pc_value_next !== m_pc + 32'd4) begin
        n_fail++;
        $display("FAIL model_deliver t=%0t got=%h/%h want=%h/%h", $time, next_instruction,
                 pc_value_next, exp_ni, m_pc + 32'd4);
      end
    end else if (exp_we) begin
      n_checks++;
      if (next_instruction !== NOP) begin
        n_fail++; $display("FAIL model_bubble t=%0t got=%h want=%h", $time, next_instruction, NOP);
      end
    end

    @(posedge clk);
    if (resp) begin
      m_out = 0;
    end else if (m_out) begin
      if (redirect_valid) m_wrong = 1;
      if (mem_cnt > 0) mem_cnt--;
    end else if (exp_req && imem_ready) begin
      m_out   = 1;
      m_wrong = m_pres_wrong || redirect_valid;
      mem_cnt = $urandom_range(2, 0);
    end
    if (exp_req && !imem_ready) begin
      m_pres_addr  = exp_addr;
      m_pres_wrong = m_pres_wrong || redirect_valid;
      m_pres       = 1;
    end else begin
      m_pres       = 0;
      m_pres_wrong = 0;
    end
    if (redirect_valid)   m_pend = 0;
    else if (m_pend)      m_pend = stall;
    else if (good && stall) begin
      m_pend = 1; m_pend_data = imem_rdata;
    end
    if (redirect_valid) m_pc = redirect_pc & 32'hFFFF_FFFC;
    else if (dlv)       m_pc = m_pc + 32'd4;
    m_idle = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    n_checks++;
    if ({imem_req, fd_write_en, fd_flush} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b want=000", {imem_req, fd_write_en, fd_flush});
    end
    n_checks++;
    if (next_instruction !== NOP || pc_value_next !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got=%h/%h want=%h/0", next_instruction, pc_value_next, NOP);
    end
    n_checks++;
    if ({w_imem_req, w_fd_write_en, w_fd_flush} !== 3'b000 || w_next_instruction !== NOP) begin
      n_fail++; $display("FAIL reset_wrap got=%b/%h", {w_imem_req, w_fd_write_en, w_fd_flush},
                         w_next_instruction);
    end
    @(negedge clk); @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req got=%b want=0", imem_req);
    end
    cyc();
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_req got=%b/%h want=1/0", imem_req, imem_addr);
    end
    n_checks++;
    if (w_imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_first_addr got=%h want=fffffffc", w_imem_addr);
    end
  endtask

  task automatic test_basic();
    imem_ready = 1;
    #1;
    n_checks++;
    if (fd_write_en !== 1'b1 || fd_flush !== 1'b1) begin
      n_fail++; $display("FAIL req_bubble got=%b%b want=11", fd_write_en, fd_flush);
    end
    cyc();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h8C01_0004;
    #1;
    n_checks++;
    if ({fd_write_en, fd_flush} !== 2'b10 || pc_value_next !== 32'h4 ||
        next_instruction !== 32'h8C01_0004) begin
      n_fail++; $display("FAIL basic_deliver got=%b%b/%h/%h want=10/4/8c010004", fd_write_en,
                         fd_flush, pc_value_next, next_instruction);
    end
    n_checks++;
    if (w_pc_value_next !== 32'h0 || w_fd_write_en !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pc_next got=%h want=0", w_pc_value_next);
    end
    cyc();
    imem_rvalid = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_fail++; $display("FAIL basic_next_addr got=%b/%h want=1/4", imem_req, imem_addr);
    end
    n_checks++;
    if (w_imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next_addr got=%h want=0", w_imem_addr);
    end
  endtask

  task automatic test_stall_hold();
    imem_ready = 1;
    cyc();
    imem_ready = 0; stall = 1; imem_rvalid = 1; imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (fd_write_en !== 1'b0 || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d] got we=%b req=%b want 0/0", i, fd_write_en, imem_req);
      end
      cyc();
      imem_rvalid = 0;
    end
    stall = 0;
    #1;
    n_checks++;
    if ({fd_write_en, fd_flush} !== 2'b10 || next_instruction !== 32'h1234_5678 ||
        pc_value_next !== 32'h8) begin
      n_fail++; $display("FAIL hold_release got=%b%b/%h/%h want=10/12345678/8", fd_write_en,
                         fd_flush, next_instruction, pc_value_next);
    end
    cyc();
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_fail++; $display("FAIL hold_next_addr got=%b/%h want=1/8", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_ready = 1;
    cyc();
    imem_ready = 0; redirect_valid = 1; redirect_pc = 32'h100;
    #1;
    n_checks++;
    if ({fd_write_en, fd_flush} !== 2'b11) begin
      n_fail++; $display("FAIL redir_wait_flush got=%b%b want=11", fd_write_en, fd_flush);
    end
    cyc();
    redirect_valid = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({fd_write_en, fd_flush} !== 2'b11 || next_instruction !== NOP) begin
      n_fail++; $display("FAIL squash_rsp got=%b%b/%h want=11/%h", fd_write_en, fd_flush,
                         next_instruction, NOP);
    end
    cyc();
    imem_rvalid = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_target got=%b/%h want=1/100", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_stall();
    imem_ready = 1;
    cyc();
    imem_ready = 0; stall = 1; redirect_valid = 1; redirect_pc = 32'h103;
    #1;
    n_checks++;
    if ({fd_write_en, fd_flush} !== 2'b11) begin
      n_fail++; $display("FAIL redir_over_stall got=%b%b want=11", fd_write_en, fd_flush);
    end
    cyc();
    stall = 0; redirect_valid = 0; imem_rvalid = 1; imem_rdata = 32'hAAAA_5555;
    cyc();
    imem_rvalid = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_align got=%b/%h want=1/100", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_req();
    redirect_valid = 1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL req_addr_stable got=%b/%h want=1/100", imem_req, imem_addr);
    end
    imem_ready = 1;
    cyc();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h0BAD_0BAD;
    #1;
    n_checks++;
    if (fd_flush !== 1'b1 || next_instruction !== NOP) begin
      n_fail++; $display("FAIL req_kill_rsp got=%b/%h want=1/%h", fd_flush, next_instruction, NOP);
    end
    cyc();
    imem_rvalid = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL req_redir_target got=%b/%h want=1/200", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_midflight();
    imem_ready = 1;
    cyc();
    imem_ready = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    imem_rvalid = 1; imem_rdata = 32'h5A5A_5A5A;
    #1;
    n_checks++;
    if ({fd_write_en, fd_flush} !== 2'b11 || next_instruction !== NOP) begin
      n_fail++; $display("FAIL late_rsp_idle got=%b%b/%h want=11/%h", fd_write_en, fd_flush,
                         next_instruction, NOP);
    end
    cyc();
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fd_flush !== 1'b1) begin
      n_fail++; $display("FAIL late_rsp_req got=%b/%h/%b want=1/0/1", imem_req, imem_addr, fd_flush);
    end
    cyc();
    imem_rvalid = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      stall          = ($urandom_range(99, 0) < 30);
      redirect_valid = ($urandom_range(99, 0) < 8);
      redirect_pc    = $urandom;
      imem_ready     = $urandom_range(1, 0);
      imem_rdata     = $urandom;
      if (m_out) imem_rvalid = (mem_cnt == 0);
      else       imem_rvalid = ($urandom_range(99, 0) < 5);
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_stall();
    test_redirect_req();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
